vga_timing_decoder: RTL and testbench

// Receive-side counterpart of the VGA sync generator. Samples h_sync, v_sync and

---
 rtl/vga_timing_decoder.sv | 222 ++++++++++++++++++++++
 tb/tb_vga_timing_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing decoder: measures line/frame lengths from incoming syncs,
// acquires lock on a stable stream and recovers active-area pixel coordinates.
module vga_timing_decoder #(
  parameter int W_H         = 11,
  parameter int W_V         = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           h_sync,
  input  logic           v_sync,
  input  logic           active_video,
  output logic [9:0]     pixel_x,
  output logic [9:0]     pixel_y,
  output logic           pixel_valid,
  output logic           line_start,
  output logic           frame_start,
  output logic [W_H-1:0] h_total_meas,
  output logic [W_V-1:0] v_total_meas,
  output logic           locked,
  output logic           timing_error
);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  localparam logic [W_H-1:0] H_MAX  = {W_H{1'b1}};
  localparam logic [W_V-1:0] V_MAX  = {W_V{1'b1}};
  localparam logic [W_H-1:0] H_ONE  = {{(W_H-1){1'b0}}, 1'b1};
  localparam logic [W_V-1:0] V_ONE  = {{(W_V-1){1'b0}}, 1'b1};
  localparam logic [3:0]     LOCK_N = 4'(LOCK_FRAMES);

  state_t         r_state, w_state_nxt;
  logic           r_h_s1, r_h_s2, r_v_s1, r_v_s2, r_de_s1, r_de_s2;
  logic [W_H-1:0] r_h_cnt, r_ref_h, r_h_total;
  logic [W_V-1:0] r_v_cnt, r_ref_v, r_v_total;
  logic [3:0]     r_match_cnt, w_match_nxt;
  logic           r_first_line, r_first_frame, w_first_line_nxt, w_first_frame_nxt;
  logic           w_load_ref_h, w_load_ref_v, w_err, w_line_bad, w_frame_bad;
  logic [9:0]     r_pixel_x, r_pixel_y;
  logic           r_pixel_valid, r_line_start, r_frame_start, r_locked, r_timing_error;

  logic           w_h_fall, w_v_fall, w_de_rise, w_de_fall, w_sat, w_line_mis, w_frame_mis;
  logic [W_H-1:0] w_line_len;
  logic [W_V-1:0] w_v_cnt_inc, w_frame_len;

  assign w_h_fall    = r_h_s2 & ~r_h_s1;
  assign w_v_fall    = r_v_s2 & ~r_v_s1;
  assign w_de_rise   = ~r_de_s2 & r_de_s1;
  assign w_de_fall   = r_de_s2 & ~r_de_s1;
  assign w_line_len  = r_h_cnt + H_ONE;
  assign w_v_cnt_inc = (r_v_cnt == V_MAX) ? V_MAX : (r_v_cnt + V_ONE);
  // A coincident h fall belongs to the frame that is ending
  assign w_frame_len = w_h_fall ? w_v_cnt_inc : r_v_cnt;
  assign w_sat       = ((r_h_cnt == H_MAX) & ~w_h_fall) | ((r_v_cnt == V_MAX) & ~w_v_fall);
  assign w_line_mis  = w_h_fall & (w_line_len != r_ref_h);
  assign w_frame_mis = w_v_fall & (w_frame_len != r_ref_v);

  // Input sampling, line/frame counters and length measurements
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {r_h_s1, r_h_s2, r_v_s1, r_v_s2} <= 4'b1111;
      {r_de_s1, r_de_s2}               <= 2'b00;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_h_total <= '0;
      r_v_total <= '0;
    end else begin
      r_h_s1  <= h_sync;
      r_h_s2  <= r_h_s1;
      r_v_s1  <= v_sync;
      r_v_s2  <= r_v_s1;
      r_de_s1 <= active_video;
      r_de_s2 <= r_de_s1;
      if (w_h_fall) begin
        r_h_cnt   <= '0;
        r_h_total <= w_line_len;
      end else if (r_h_cnt != H_MAX) begin
        r_h_cnt <= r_h_cnt + H_ONE;
      end
      if (w_v_fall) begin
        r_v_cnt   <= '0;
        r_v_total <= w_frame_len;
      end else if (w_h_fall) begin
        r_v_cnt <= w_v_cnt_inc;
      end
    end
  end

  // Lock FSM next state; in ACQUIRE the first line/frame after entry only seeds the refs
  always_comb begin
    w_state_nxt       = r_state;
    w_err             = 1'b0;
    w_match_nxt       = r_match_cnt;
    w_load_ref_h      = 1'b0;
    w_load_ref_v      = 1'b0;
    w_first_line_nxt  = r_first_line;
    w_first_frame_nxt = r_first_frame;
    w_line_bad        = 1'b0;
    w_frame_bad       = 1'b0;
    case (r_state)
      S_SEARCH: begin
        if (w_v_fall) begin
          w_state_nxt       = S_ACQUIRE;
          w_load_ref_h      = 1'b1;
          w_load_ref_v      = 1'b1;
          w_match_nxt       = 4'd0;
          w_first_line_nxt  = 1'b1;
          w_first_frame_nxt = 1'b1;
        end else begin
          w_match_nxt = 4'd0;
        end
      end
      S_ACQUIRE: begin
        if (w_sat) begin
          w_state_nxt = S_SEARCH;
        end else begin
          w_line_bad   = w_line_mis & ~r_first_line;
          w_frame_bad  = w_frame_mis & ~r_first_frame;
          w_load_ref_h = w_h_fall;
          w_load_ref_v = w_v_fall;
          if (w_h_fall) begin
            w_first_line_nxt = 1'b0;
          end else begin
            w_first_line_nxt = r_first_line;
          end
          if (w_v_fall) begin
            w_first_frame_nxt = 1'b0;
          end else begin
            w_first_frame_nxt = r_first_frame;
          end
          if (w_line_bad | w_frame_bad) begin
            w_err       = 1'b1;
            w_match_nxt = 4'd0;
          end else if (w_v_fall) begin
            w_match_nxt = r_match_cnt + 4'd1;
          end else begin
            w_match_nxt = r_match_cnt;
          end
          if (w_match_nxt >= LOCK_N) begin
            w_state_nxt = S_LOCKED;
          end else begin
            w_state_nxt = S_ACQUIRE;
          end
        end
      end
      S_LOCKED: begin
        if (w_sat | w_line_mis | w_frame_mis) begin
          w_err       = 1'b1;
          w_state_nxt = S_SEARCH;
        end else begin
          w_state_nxt = S_LOCKED;
        end
      end
      default: begin
        w_state_nxt = S_SEARCH;
      end
    endcase
  end

  // Lock FSM state register and reference lengths
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_SEARCH;
      r_ref_h       <= '0;
      r_ref_v       <= '0;
      r_match_cnt   <= 4'd0;
      r_first_line  <= 1'b0;
      r_first_frame <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_match_cnt   <= w_match_nxt;
      r_first_line  <= w_first_line_nxt;
      r_first_frame <= w_first_frame_nxt;
      if (w_load_ref_h) r_ref_h <= w_line_len;
      if (w_load_ref_v) r_ref_v <= w_frame_len;
    end
  end

  // Registered status pulses and active-area coordinates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pixel_x      <= 10'd0;
      r_pixel_y      <= 10'd0;
      r_pixel_valid  <= 1'b0;
      r_line_start   <= 1'b0;
      r_frame_start  <= 1'b0;
      r_locked       <= 1'b0;
      r_timing_error <= 1'b0;
    end else begin
      if (w_de_rise) begin
        r_pixel_x <= 10'd0;
      end else if (r_de_s1) begin
        r_pixel_x <= r_pixel_x + 10'd1;
      end
      if (w_v_fall) begin
        r_pixel_y <= 10'd0;
      end else if (w_de_fall) begin
        r_pixel_y <= r_pixel_y + 10'd1;
      end
      r_pixel_valid  <= r_de_s1 & (w_state_nxt == S_LOCKED);
      r_line_start   <= w_h_fall;
      r_frame_start  <= w_v_fall;
      r_locked       <= (w_state_nxt == S_LOCKED);
      r_timing_error <= w_err;
    end
  end

  assign pixel_x      = r_pixel_x;
  assign pixel_y      = r_pixel_y;
  assign pixel_valid  = r_pixel_valid;
  assign line_start   = r_line_start;
  assign frame_start  = r_frame_start;
  assign h_total_meas = r_h_total;
  assign v_total_meas = r_v_total;
  assign locked       = r_locked;
  assign timing_error = r_timing_error;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder on a reduced 72x68 raster with a 64x64
// active window; each task drives one scenario and checks its own results.
module tb_vga_timing_decoder;

  localparam int HT  = 72;  // clocks per line
  localparam int VT  = 68;  // lines per frame
  localparam int HS  = 8;   // h_sync low width / first active column offset
  localparam int VS  = 2;   // v_sync low lines
  localparam int VB  = 4;   // first active line
  localparam int ACT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        h_sync = 1'b1, v_sync = 1'b1, active_video = 1'b0;
  logic [9:0]  pixel_x, pixel_y;
  logic        pixel_valid, line_start, frame_start, locked, timing_error;
  logic [10:0] h_total_meas;
  logic [9:0]  v_total_meas;

  always #5 clk = ~clk;

  vga_timing_decoder #(.W_H(11), .W_V(10), .LOCK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
    .active_video(active_video), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_valid(pixel_valid), .line_start(line_start), .frame_start(frame_start),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas), .locked(locked),
    .timing_error(timing_error)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;
  int ls_cnt, fs_cnt, both_cnt, te_cnt, te_cyc, lock_cyc, unlock_cyc, fs_cyc;
  int pv_cnt, pv_last, coord_err, mark_cyc;
  bit prev_locked = 1'b0, prev_v = 1'b1;
  bit d1_de = 1'b0, d2_de = 1'b0;
  int d1_c = 0, d1_r = 0, d2_c = 0, d2_r = 0;
  int vf_q[$];

  task automatic clear_mon();
    ls_cnt = 0; fs_cnt = 0; both_cnt = 0; te_cnt = 0; te_cyc = -1;
    lock_cyc = -1; unlock_cyc = -1; fs_cyc = -1; pv_cnt = 0; pv_last = 0;
    coord_err = 0; mark_cyc = -1;
    vf_q.delete();
  endtask

  // One pixel clock: sample outputs (driven two clocks ago), then apply new inputs
  task automatic drive_cycle(input bit h, input bit v, input bit de, input int c, input int r);
    @(negedge clk);
    cyc++;
    if (line_start) ls_cnt++;
    if (frame_start) begin
      fs_cnt++;
      if (fs_cyc < 0) fs_cyc = cyc;
      pv_last = pv_cnt;
      pv_cnt  = 0;
    end
    if (line_start && frame_start) both_cnt++;
    if (timing_error) begin
      te_cnt++;
      te_cyc = cyc;
    end
    if (locked && !prev_locked && lock_cyc < 0) lock_cyc = cyc;
    if (!locked && prev_locked) unlock_cyc = cyc;
    prev_locked = locked;
    if (pixel_valid) begin
      pv_cnt++;
      if (!d2_de || pixel_x !== 10'(d2_c) || pixel_y !== 10'(d2_r)) coord_err++;
    end
    if (prev_v && !v) vf_q.push_back(cyc);
    prev_v = v;
    d2_de = d1_de; d2_c = d1_c; d2_r = d1_r;
    d1_de = de;    d1_c = c;    d1_r = r;
    h_sync = h; v_sync = v; active_video = de;
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic drive_line(input int len, input int li);
    for (int i = 0; i < len; i++)
      drive_cycle((i >= HS), (li >= VS), (li >= VB) && (i >= HS) && (i < HS + ACT),
                  i - HS, li - VB);
  endtask

  task automatic drive_frame(input int stretch_li);
    for (int li = 0; li < VT; li++) begin
      if (li == stretch_li + 1) mark_cyc = cyc + 1;
      drive_line((li == stretch_li) ? HT + 1 : HT, li);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle(4);
    n_tests++;
    if ({pixel_x, pixel_y} !== 20'd0) begin
      n_fail++; $display("FAIL reset_pixel_xy: got %0h expected 0", {pixel_x, pixel_y});
    end
    n_tests++;
    if ({pixel_valid, line_start, frame_start, locked, timing_error} !== 5'd0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000",
                         {pixel_valid, line_start, frame_start, locked, timing_error});
    end
    n_tests++;
    if ({h_total_meas, v_total_meas} !== 21'd0) begin
      n_fail++; $display("FAIL reset_meas: got %0d/%0d expected 0/0", h_total_meas, v_total_meas);
    end
    reset = 1'b1;
    clear_mon();
    drive_idle(6);
    n_tests++;
    if (ls_cnt + fs_cnt !== 0) begin
      n_fail++; $display("FAIL reset_no_pulse: got %0d pulses expected 0", ls_cnt + fs_cnt);
    end
  endtask

  task automatic test_lock();
    clear_mon();
    repeat (4) drive_frame(-1);
    n_tests++;
    if (lock_cyc !== vf_q[2] + 2) begin
      n_fail++; $display("FAIL lock_time: got cycle %0d expected %0d", lock_cyc, vf_q[2] + 2);
    end
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL lock_level: got %b expected 1", locked);
    end
    n_tests++;
    if (h_total_meas !== 11'd72) begin
      n_fail++; $display("FAIL h_total: got %0d expected 72", h_total_meas);
    end
    n_tests++;
    if (v_total_meas !== 10'd68) begin
      n_fail++; $display("FAIL v_total: got %0d expected 68", v_total_meas);
    end
    n_tests++;
    if (pv_last !== 4096) begin
      n_fail++; $display("FAIL pixel_count: got %0d expected 4096", pv_last);
    end
    n_tests++;
    if (coord_err !== 0) begin
      n_fail++; $display("FAIL pixel_coords: got %0d bad pixels expected 0", coord_err);
    end
    n_tests++;
    if (te_cnt !== 0) begin
      n_fail++; $display("FAIL lock_no_error: got %0d errors expected 0", te_cnt);
    end
    n_tests++;
    if (ls_cnt !== 4 * VT || fs_cnt !== 4) begin
      n_fail++; $display("FAIL pulse_counts: got %0d/%0d expected %0d/4", ls_cnt, fs_cnt, 4 * VT);
    end
    n_tests++;
    if (both_cnt !== 4) begin
      n_fail++; $display("FAIL coincident_falls: got %0d expected 4", both_cnt);
    end
  endtask

  task automatic test_stretch();
    clear_mon();
    drive_frame(10);
    n_tests++;
    if (te_cnt !== 1 || te_cyc !== mark_cyc + 2) begin
      n_fail++; $display("FAIL stretch_error: got %0d pulses at %0d expected 1 at %0d",
                         te_cnt, te_cyc, mark_cyc + 2);
    end
    n_tests++;
    if (locked !== 1'b0 || unlock_cyc !== te_cyc) begin
      n_fail++; $display("FAIL stretch_unlock: got locked=%b at %0d expected 0 at %0d",
                         locked, unlock_cyc, te_cyc);
    end
    lock_cyc = -1;
    vf_q.delete();
    repeat (3) drive_frame(-1);
    n_tests++;
    if (lock_cyc !== vf_q[2] + 2 || te_cnt !== 1) begin
      n_fail++; $display("FAIL stretch_relock: got cycle %0d errs %0d expected %0d errs 1",
                         lock_cyc, te_cnt, vf_q[2] + 2);
    end
  endtask

  task automatic test_saturation();
    clear_mon();
    drive_idle(2048);
    n_tests++;
    if (te_cnt !== 1 || locked !== 1'b0) begin
      n_fail++; $display("FAIL sat_error: got %0d errs locked=%b expected 1 errs locked=0",
                         te_cnt, locked);
    end
    lock_cyc = -1;
    vf_q.delete();
    repeat (3) drive_frame(-1);
    n_tests++;
    if (lock_cyc !== vf_q[2] + 2 || te_cnt !== 1) begin
      n_fail++; $display("FAIL sat_relock: got cycle %0d errs %0d expected %0d errs 1",
                         lock_cyc, te_cnt, vf_q[2] + 2);
    end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    for (int li = 0; li < 30; li++) drive_line(HT, li);
    n_tests++;
    if (locked !== 1'b1 || h_total_meas !== 11'd72) begin
      n_fail++; $display("FAIL midframe_pre: got locked=%b h=%0d expected 1/72", locked, h_total_meas);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({pixel_x, pixel_y, pixel_valid, line_start, frame_start, locked, timing_error} !== 25'd0 ||
        {h_total_meas, v_total_meas} !== 21'd0) begin
      n_fail++; $display("FAIL midframe_async: got %0d/%0d/%b/%0d/%0d expected all 0",
                         pixel_x, pixel_y, locked, h_total_meas, v_total_meas);
    end
    drive_idle(3);
    reset = 1'b1;
    clear_mon();
    drive_idle(20);
    n_tests++;
    if (ls_cnt + fs_cnt !== 0) begin
      n_fail++; $display("FAIL midframe_no_pulse: got %0d pulses expected 0", ls_cnt + fs_cnt);
    end
    drive_frame(-1);
    n_tests++;
    if (fs_cyc !== vf_q[0] + 2 || locked !== 1'b0) begin
      n_fail++; $display("FAIL midframe_first_fall: got cycle %0d locked=%b expected %0d locked=0",
                         fs_cyc, locked, vf_q[0] + 2);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_stretch();
    test_saturation();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
